// File: rtl/iob_cache_front_arbiter.sv
// iob_cache_front_arbiter: round-robin sharing of one IOb cache front-end port among N_MASTERS requesters,
// one transaction outstanding, read responses steered back to the issuing requester.
module iob_cache_front_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                          clk_i,
    input  logic                          cke_i,
    input  logic                          arst_i,
    input  logic [N_MASTERS-1:0]          s_avalid_i,
    input  logic [N_MASTERS*ADDR_W-1:0]   s_addr_i,
    input  logic [N_MASTERS*DATA_W-1:0]   s_wdata_i,
    input  logic [N_MASTERS*DATA_W/8-1:0] s_wstrb_i,
    input  logic [N_MASTERS*4-1:0]        s_acache_i,
    output logic [N_MASTERS-1:0]          s_ready_o,
    output logic [N_MASTERS-1:0]          s_rvalid_o,
    output logic [DATA_W-1:0]             s_rdata_o,
    output logic                          m_avalid_o,
    output logic [ADDR_W-1:0]             m_addr_o,
    output logic [DATA_W-1:0]             m_wdata_o,
    output logic [DATA_W/8-1:0]           m_wstrb_o,
    output logic [3:0]                    m_acache_o,
    input  logic                          m_ready_i,
    input  logic                          m_rvalid_i,
    input  logic [DATA_W-1:0]             m_rdata_i
);
    localparam int GW = $clog2(N_MASTERS);
    localparam int SW = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t        state, state_nx;
    logic [GW-1:0] grant, grant_nx, rr_ptr, rr_nx, winner, cand;
    logic          is_read, is_read_nx, accept;
    logic [SW-1:0] g_wstrb;

    function automatic logic [GW-1:0] wrap(input logic [GW:0] v);
        return (v >= (GW+1)'(N_MASTERS)) ? GW'(v - (GW+1)'(N_MASTERS)) : GW'(v);
    endfunction

    assign g_wstrb   = s_wstrb_i[grant*SW +: SW];
    assign accept    = (state == REQ) && s_avalid_i[grant] && m_ready_i;
    assign s_rdata_o = m_rdata_i;

    // scan downward so the lowest offset from rr_ptr wins
    always_comb begin
        winner = rr_ptr;
        cand   = rr_ptr;
        for (int k = N_MASTERS - 1; k >= 0; k--) begin
            cand = wrap({1'b0, rr_ptr} + (GW+1)'(k));
            if (s_avalid_i[cand]) winner = cand;
        end
    end

    always_comb begin
        state_nx   = state;
        grant_nx   = grant;
        rr_nx      = rr_ptr;
        is_read_nx = is_read;
        if (state == IDLE && |s_avalid_i) begin
            state_nx = REQ;
            grant_nx = winner;
        end else if (state == REQ && !s_avalid_i[grant]) begin
            state_nx = IDLE;
        end else if (accept) begin
            rr_nx      = wrap({1'b0, grant} + (GW+1)'(1));
            is_read_nx = ~|g_wstrb;
            state_nx   = ~|g_wstrb ? WAIT : IDLE;
        end else if (state == WAIT && m_rvalid_i) begin
            state_nx = IDLE;
        end
    end

    always_comb begin
        m_avalid_o = 1'b0;
        m_addr_o   = '0;
        m_wdata_o  = '0;
        m_wstrb_o  = '0;
        m_acache_o = '0;
        s_ready_o  = '0;
        s_rvalid_o = '0;
        if (state == REQ) begin
            m_avalid_o       = s_avalid_i[grant];
            m_addr_o         = s_addr_i[grant*ADDR_W +: ADDR_W];
            m_wdata_o        = s_wdata_i[grant*DATA_W +: DATA_W];
            m_wstrb_o        = g_wstrb;
            m_acache_o       = s_acache_i[grant*4 +: 4];
            s_ready_o[grant] = m_ready_i;
        end
        if (state == WAIT) s_rvalid_o[grant] = m_rvalid_i & is_read;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state   <= IDLE;
            grant   <= '0;
            rr_ptr  <= '0;
            is_read <= 1'b0;
        end else if (cke_i) begin
            state   <= state_nx;
            grant   <= grant_nx;
            rr_ptr  <= rr_nx;
            is_read <= is_read_nx;
        end
    end
endmodule

// File: tb/tb_iob_cache_front_arbiter.sv
// tb_iob_cache_front_arbiter: randomized round-robin stimulus with a queue-based scoreboard;
// expected issue order comes from a list-level round-robin model, checked by an independent monitor.
module tb_iob_cache_front_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    typedef struct {
        int          idx;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
        logic [3:0]    acache;
    } txn_t;

    logic clk = 1'b0, cke = 1'b1, arst = 1'b1;
    logic [N-1:0]    s_avalid = '0;
    logic [AW-1:0]   r_addr[N];
    logic [DW-1:0]   r_wdata[N];
    logic [SW-1:0]   r_wstrb[N];
    logic [3:0]      r_acache[N];
    logic [N*AW-1:0] s_addr;
    logic [N*DW-1:0] s_wdata;
    logic [N*SW-1:0] s_wstrb;
    logic [N*4-1:0]  s_acache;
    logic [N-1:0]    s_ready, s_rvalid;
    logic [DW-1:0]   s_rdata;
    logic            m_avalid, m_ready, m_rvalid;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata, m_rdata;
    logic [SW-1:0]   m_wstrb;
    logic [3:0]      m_acache;

    logic            manual = 1'b0, man_ready = 1'b0, man_rvalid = 1'b0;
    logic [DW-1:0]   man_rdata = '0;
    logic            c_ready = 1'b0, c_rvalid = 1'b0;
    logic [DW-1:0]   c_rdata = '0;
    int              cyc = 0, low_until = 0, fixed_dly = -1;

    txn_t exp_q[$];
    int   resp_q[$];
    int   n_cmp = 0, n_err = 0, m_rr = 0;
    logic [N-1:0] snap_sacc = '0, snap_rv = '0, act = '0, waitr = '0;
    logic snap_macc_rd = 1'b0;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign s_addr[g*AW +: AW]   = r_addr[g];
        assign s_wdata[g*DW +: DW]  = r_wdata[g];
        assign s_wstrb[g*SW +: SW]  = r_wstrb[g];
        assign s_acache[g*4 +: 4]   = r_acache[g];
    end
    assign m_ready  = manual ? man_ready  : c_ready;
    assign m_rvalid = manual ? man_rvalid : c_rvalid;
    assign m_rdata  = manual ? man_rdata  : c_rdata;

    iob_cache_front_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i(clk), .cke_i(cke), .arst_i(arst),
        .s_avalid_i(s_avalid), .s_addr_i(s_addr), .s_wdata_i(s_wdata),
        .s_wstrb_i(s_wstrb), .s_acache_i(s_acache),
        .s_ready_o(s_ready), .s_rvalid_o(s_rvalid), .s_rdata_o(s_rdata),
        .m_avalid_o(m_avalid), .m_addr_o(m_addr), .m_wdata_o(m_wdata),
        .m_wstrb_o(m_wstrb), .m_acache_o(m_acache),
        .m_ready_i(m_ready), .m_rvalid_i(m_rvalid), .m_rdata_i(m_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // monitor: sampled mid-cycle, describing what the next rising edge will do
    initial begin
        txn_t t;
        int   ri;
        forever begin
            @(negedge clk);
            snap_sacc    = '0;
            snap_rv      = '0;
            snap_macc_rd = 1'b0;
            if (!arst && cke) begin
                chk("ready_onehot", 64'($countones(s_ready) <= 1), 64'd1);
                if (m_avalid && exp_q.size() > 0) begin
                    chk("ready_follow", 64'(s_ready), m_ready ? (64'd1 << exp_q[0].idx) : 64'd0);
                    chk("req_addr", 64'(m_addr), 64'(exp_q[0].addr));
                end
                if (m_avalid && m_ready) begin
                    if (exp_q.size() == 0) chk("unexpected_accept", 64'd1, 64'd0);
                    else begin
                        t = exp_q.pop_front();
                        chk("acc_addr", 64'(m_addr), 64'(t.addr));
                        chk("acc_wdata", 64'(m_wdata), 64'(t.wdata));
                        chk("acc_wstrb", 64'(m_wstrb), 64'(t.wstrb));
                        chk("acc_acache", 64'(m_acache), 64'(t.acache));
                        if (t.wstrb == 0) resp_q.push_back(t.idx);
                    end
                    snap_macc_rd = (m_wstrb == 0);
                end
                if (s_rvalid != 0) begin
                    if (resp_q.size() == 0) chk("unexpected_rvalid", 64'(s_rvalid), 64'd0);
                    else begin
                        ri = resp_q.pop_front();
                        chk("rvalid_idx", 64'(s_rvalid), 64'd1 << ri);
                        chk("rdata", 64'(s_rdata), 64'(m_rdata));
                    end
                end
                snap_sacc = s_ready & s_avalid;
                snap_rv   = s_rvalid;
            end
        end
    end

    // cache model: random ready, read data after a short random delay
    initial begin
        bit pend = 0;
        int cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            c_rvalid = 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    c_rvalid = 1'b1;
                    c_rdata  = $urandom;
                    pend     = 0;
                end else cnt--;
            end
            if (snap_macc_rd && !manual) begin
                pend = 1;
                cnt  = fixed_dly >= 0 ? fixed_dly : int'($urandom_range(0, 3));
            end
            c_ready = (cyc < low_until) ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    task automatic serve();
        int n = 0;
        while ((act | waitr) != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
            for (int i = 0; i < N; i++) begin
                if (act[i] && snap_sacc[i]) begin
                    act[i]      = 1'b0;
                    s_avalid[i] = 1'b0;
                    if (r_wstrb[i] == 0) waitr[i] = 1'b1;
                end else if (waitr[i] && snap_rv[i]) waitr[i] = 1'b0;
            end
        end
        if ((act | waitr) != 0) begin
            chk("serve_timeout", 64'(act | waitr), 64'd0);
            s_avalid = '0;
            act      = '0;
            waitr    = '0;
            exp_q.delete();
            resp_q.delete();
        end
    endtask

    // wmode: 0 read, 1 write, 2 random; all masked requesters raise avalid together
    task automatic run_round(input logic [N-1:0] mask, input int wmode, input bit fixa = 0);
        int order[$];
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                r_addr[i]   = fixa ? 32'h40 : $urandom;
                r_wdata[i]  = $urandom;
                r_wstrb[i]  = wmode == 0 ? 4'h0 : wmode == 1 ? 4'hF :
                              ($urandom_range(0, 1) != 0 ? 4'($urandom_range(1, 15)) : 4'h0);
                r_acache[i] = 4'($urandom);
            end
        end
        for (int k = 0; k < N; k++)
            if (mask[(m_rr + k) % N]) order.push_back((m_rr + k) % N);
        foreach (order[j])
            exp_q.push_back('{order[j], r_addr[order[j]], r_wdata[order[j]], r_wstrb[order[j]], r_acache[order[j]]});
        m_rr     = (order[order.size()-1] + 1) % N;
        s_avalid = mask;
        act      = mask;
        waitr    = '0;
        #1;
        chk("lat_idle", 64'(m_avalid), 64'd0);
        @(posedge clk);
        #1;
        chk("lat_req", 64'(m_avalid), 64'd1);
        serve();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            r_addr[i] = '0; r_wdata[i] = '0; r_wstrb[i] = '0; r_acache[i] = '0;
        end
        s_avalid = '1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_avalid", 64'(m_avalid), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_s_rvalid", 64'(s_rvalid), 64'd0);
        chk("rst_m_addr", 64'(m_addr), 64'd0);
        s_avalid = '0;
        #1;
        arst = 1'b0;
        @(posedge clk);
        #1;

        run_round(4'b0011, 0);
        fixed_dly = 2;
        run_round(4'b0010, 0, 1);
        fixed_dly = -1;
        low_until = cyc + 3;
        run_round(4'b0001, 1);
        low_until = cyc + 3;
        run_round(4'b0001, 1);
        repeat (3) run_round(4'b1111, 2);

        // abort in REQ: nothing issued, rr pointer unchanged
        manual = 1'b1; man_ready = 1'b0; man_rvalid = 1'b0;
        r_addr[2] = $urandom; r_wstrb[2] = '0; s_avalid[2] = 1'b1;
        @(posedge clk); #1;
        chk("abort_req", 64'(m_avalid), 64'd1);
        chk("abort_addr", 64'(m_addr), 64'(r_addr[2]));
        @(posedge clk); #1;
        s_avalid[2] = 1'b0;
        #1;
        chk("abort_drop", 64'(m_avalid), 64'd0);
        man_ready = 1'b1;
        @(posedge clk); #1;
        chk("abort_idle_ready", 64'(s_ready), 64'd0);
        chk("abort_idle_addr", 64'(m_addr), 64'd0);
        man_ready = 1'b0; manual = 1'b0;
        run_round(4'b1100, 0);

        // clock enable low while in REQ with the cache ready
        manual = 1'b1; man_ready = 1'b0;
        r_addr[1] = $urandom; r_wdata[1] = $urandom; r_wstrb[1] = 4'hF; r_acache[1] = 4'($urandom);
        exp_q.push_back('{1, r_addr[1], r_wdata[1], r_wstrb[1], r_acache[1]});
        m_rr = 2;
        s_avalid[1] = 1'b1; act = 4'b0010; waitr = '0;
        @(posedge clk); #1;
        chk("cke_req", 64'(m_avalid), 64'd1);
        cke = 1'b0; man_ready = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("cke_hold_avalid", 64'(m_avalid), 64'd1);
            chk("cke_hold_addr", 64'(m_addr), 64'(r_addr[1]));
        end
        man_ready = 1'b0; cke = 1'b1;
        @(posedge clk); #1;
        chk("cke_still_req", 64'(m_avalid), 64'd1);
        manual = 1'b0;
        serve();

        // reset while waiting for read data drops the response and the rr pointer
        manual = 1'b1; man_ready = 1'b1; man_rvalid = 1'b0;
        r_addr[1] = $urandom; r_wstrb[1] = '0;
        exp_q.push_back('{1, r_addr[1], r_wdata[1], r_wstrb[1], r_acache[1]});
        s_avalid[1] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        s_avalid[1] = 1'b0; man_ready = 1'b0;
        chk("wait_avalid", 64'(m_avalid), 64'd0);
        man_rvalid = 1'b1; man_rdata = $urandom;
        #1;
        chk("wait_rvalid", 64'(s_rvalid), 64'b0010);
        arst = 1'b1;
        #1;
        chk("arst_rvalid", 64'(s_rvalid), 64'd0);
        chk("arst_ready", 64'(s_ready), 64'd0);
        man_rvalid = 1'b0;
        @(posedge clk); #1;
        arst = 1'b0;
        resp_q.delete();
        m_rr = 0; manual = 1'b0;
        @(posedge clk); #1;
        run_round(4'b1010, 0);

        repeat (60) run_round(4'($urandom_range(1, 15)), 2);
        repeat (4) @(posedge clk);
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        chk("resp_q_drained", 64'(resp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
